// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stop-vector layout, stall patterns,
// default exception codes and the divide-stall FSM state type.
package pipe_ctrl_pkg;

   localparam int unsigned STOP_PC    = 0;
   localparam int unsigned STOP_IF_ID = 1;
   localparam int unsigned STOP_ID_EX = 2;
   localparam int unsigned STOP_EX_MEM = 3;
   localparam int unsigned STOP_MEM_WB = 4;
   localparam int unsigned STOP_RSVD  = 5;

   localparam logic [5:0] STOP_NONE = 6'b000000;
   localparam logic [5:0] STOP_IF   = 6'b000011;
   localparam logic [5:0] STOP_ID   = 6'b000111;
   localparam logic [5:0] STOP_DIV  = 6'b001111;
   localparam logic [5:0] STOP_MEM  = 6'b011111;

   localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR  = 32'h0000_0020;
   localparam logic [31:0] DEF_ERET_TYPE   = 32'h0000_000e;

   typedef enum logic [0:0] {
      StIdle,
      StDivWait
   } state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: merges stage stall requests, the counted divide stall and
// exception/ERET flushes into the stop vector plus the flush/new_pc redirect pair.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
   parameter logic [31:0] ERET_TYPE  = DEF_ERET_TYPE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_mem,
   input  logic        div_start,
   input  logic [31:0] excepttype,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stop,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        div_busy
);

   localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flush    = (excepttype != ZERO_WORD);
      new_pc   = ZERO_WORD;
      div_busy = 1'b0;
      stop     = STOP_NONE;

      if (flush) begin
         new_pc = (excepttype == ERET_TYPE) ? cp0_epc : EXC_VECTOR;
      end

      unique case (state_q)
         StIdle: begin
            div_busy = div_start && !flush;
            if (div_start && !flush) begin
               state_d = StDivWait;
               cnt_d   = CNT_W'(DIV_CYCLES - 1);
            end
         end
         StDivWait: begin
            div_busy = !flush;
            if (flush) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               // Arrive in idle together with cnt reaching zero, so the stall
               // spans exactly DIV_CYCLES cycles from the start pulse.
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      if (flush) begin
         stop = STOP_NONE;
      end else if (stallreq_mem) begin
         stop = STOP_MEM;
      end else if (div_busy) begin
         stop = STOP_DIV;
      end else if (stallreq_id) begin
         stop = STOP_ID;
      end else if (stallreq_if) begin
         stop = STOP_IF;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations per
// cycle, an independent monitor pops and compares them on the falling edge.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_mem;
   logic        div_start;
   logic [31:0] excepttype;
   logic [31:0] cp0_epc;
   logic [5:0]  stop;
   logic        flush;
   logic [31:0] new_pc;
   logic        div_busy;

   typedef struct {
      string       name;
      logic [5:0]  stop;
      logic        flush;
      logic [31:0] new_pc;
      logic        div_busy;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   pipe_ctrl #(
      .DIV_CYCLES(4),
      .EXC_VECTOR(32'h0000_0020),
      .ERET_TYPE (32'h0000_000e)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stallreq_if (stallreq_if),
      .stallreq_id (stallreq_id),
      .stallreq_mem(stallreq_mem),
      .div_start   (div_start),
      .excepttype  (excepttype),
      .cp0_epc     (cp0_epc),
      .stop        (stop),
      .flush       (flush),
      .new_pc      (new_pc),
      .div_busy    (div_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the rising edge and queue what the
   // outputs must show for that cycle.
   task automatic step(input string nm, input logic rn, input logic sif, input logic sid,
                       input logic smem, input logic ds, input logic [31:0] exc,
                       input logic [31:0] epc, input logic [5:0] e_stop, input logic e_flush,
                       input logic [31:0] e_pc, input logic e_busy);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = rn;
      stallreq_if  = sif;
      stallreq_id  = sid;
      stallreq_mem = smem;
      div_start    = ds;
      excepttype   = exc;
      cp0_epc      = epc;
      e.name     = nm;
      e.stop     = e_stop;
      e.flush    = e_flush;
      e.new_pc   = e_pc;
      e.div_busy = e_busy;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (stop !== e.stop || flush !== e.flush || new_pc !== e.new_pc ||
                div_busy !== e.div_busy) begin
               errors++;
               $display("FAIL %s: got stop=%b flush=%b new_pc=%h div_busy=%b, want stop=%b flush=%b new_pc=%h div_busy=%b",
                        e.name, stop, flush, new_pc, div_busy,
                        e.stop, e.flush, e.new_pc, e.div_busy);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b0;
      div_start = 1'b0; excepttype = '0; cp0_epc = '0;

      step("reset",      0, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      step("idle",       1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      // Stall priority
      step("prio_all",   1, 1, 1, 1, 0, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 0);
      step("prio_id",    1, 1, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 0);
      step("prio_if",    1, 1, 0, 0, 0, 32'h0, 32'h0, 6'b000011, 0, 32'h0, 0);
      step("quiet",      1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      // Plain divide, second pulse inside the stall ignored
      step("div_t0",     1, 0, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("div_t1",     1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("div_t2_re",  1, 0, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("div_t3",     1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("div_t4_end", 1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      step("div_t5_id",  1, 0, 1, 0, 0, 32'h0, 32'h0, 6'b000111, 0, 32'h0, 0);
      // Divide overlapped by a MEM stall keeps its length
      step("dm_t0",      1, 0, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("dm_t1_mem",  1, 0, 0, 1, 0, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 1);
      step("dm_t2_mem",  1, 0, 0, 1, 0, 32'h0, 32'h0, 6'b011111, 0, 32'h0, 1);
      step("dm_t3",      1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("dm_t4_end",  1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      // Exception aborts a divide
      step("ex_t0",      1, 0, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("ex_t1",      1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("ex_t2_exc",  1, 0, 0, 1, 0, 32'h1, 32'h0, 6'b000000, 1, 32'h20, 0);
      step("ex_t3_abrt", 1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      // Exception with a start pulse in the same cycle
      step("exds_t0",    1, 0, 0, 0, 1, 32'h4, 32'h0, 6'b000000, 1, 32'h20, 0);
      step("exds_t1",    1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      // ERET redirects to EPC and beats a MEM stall
      step("eret",       1, 0, 0, 0, 0, 32'he, 32'h8000_0104, 6'b000000, 1, 32'h8000_0104, 0);
      step("eret_mem",   1, 1, 1, 1, 0, 32'he, 32'h8000_0104, 6'b000000, 1, 32'h8000_0104, 0);
      step("epc_nouse",  1, 0, 0, 0, 0, 32'h0, 32'h8000_0104, 6'b000000, 0, 32'h0, 0);
      // Asynchronous reset in the middle of a divide
      step("rst_t0",     1, 0, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("rst_t1",     1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);
      step("rst_mid",    0, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      step("rst_rel",    1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      step("rst_after",  1, 0, 0, 0, 0, 32'h0, 32'h0, 6'b000000, 0, 32'h0, 0);
      step("rst_restart",1, 0, 0, 0, 1, 32'h0, 32'h0, 6'b001111, 0, 32'h0, 1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
